// File: rtl/alien_sprite_drawer.sv
// Erases the previous alien sprite box and redraws the bitmap whenever the alien moves.
// Optional ALIEN_SPRITE_ANIM_EN adds a second pose that alternates on every move.
module alien_sprite_drawer #(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8,
    parameter logic [SPR_W*SPR_H-1:0] SPRITE_BITS = 64'h3C7EDBFFFF246681,
`ifdef ALIEN_SPRITE_ANIM_EN
    parameter logic [SPR_W*SPR_H-1:0] SPRITE_BITS_B = 64'h3C7EDBFFFF5A8142,
`endif
    parameter logic [2:0] ALIEN_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alien_x,
    input  logic [6:0] alien_y,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       draw_done
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int BW = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1;

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cx, cx_n;
    logic [RW-1:0] cy, cy_n;
    logic [7:0]    last_x, last_x_n, new_x, new_x_n;
    logic [6:0]    last_y, last_y_n, new_y, new_y_n;
    logic          first, first_n;
    logic [7:0]    plot_x_n;
    logic [6:0]    plot_y_n;
    logic [2:0]    colour_n;
    logic          plot_n, busy_n, draw_done_n;

    logic [7:0]    base_x;
    logic [6:0]    base_y;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;
    logic          on_screen;
    logic [BW-1:0] bit_idx;
    logic          sprite_bit;

`ifdef ALIEN_SPRITE_ANIM_EN
    logic frame_sel, frame_sel_n;
`endif

    // Sums are one bit wider than the screen field so off-screen pixels are detected, not wrapped.
    assign base_x    = (state == ERASE) ? last_x : new_x;
    assign base_y    = (state == ERASE) ? last_y : new_y;
    assign sum_x     = {1'b0, base_x} + 9'(cx);
    assign sum_y     = {1'b0, base_y} + 8'(cy);
    assign on_screen = (sum_x < 9'(SCR_W)) && (sum_y < 8'(SCR_H));
    assign bit_idx   = BW'(cy * SPR_W + cx);

`ifdef ALIEN_SPRITE_ANIM_EN
    assign sprite_bit = frame_sel ? SPRITE_BITS_B[bit_idx] : SPRITE_BITS[bit_idx];
`else
    assign sprite_bit = SPRITE_BITS[bit_idx];
`endif

    always_comb begin
        state_n     = state;
        cx_n        = cx;
        cy_n        = cy;
        last_x_n    = last_x;
        last_y_n    = last_y;
        new_x_n     = new_x;
        new_y_n     = new_y;
        first_n     = first;
        plot_x_n    = plot_x;
        plot_y_n    = plot_y;
        colour_n    = colour;
        plot_n      = 1'b0;
        busy_n      = busy;
        draw_done_n = 1'b0;
`ifdef ALIEN_SPRITE_ANIM_EN
        frame_sel_n = frame_sel;
`endif
        case (state)
            IDLE: begin
                if (first || (alien_x != last_x) || (alien_y != last_y)) begin
                    new_x_n = alien_x;
                    new_y_n = alien_y;
                    cx_n    = '0;
                    cy_n    = '0;
                    busy_n  = 1'b1;
                    state_n = first ? DRAW : ERASE;
                end
            end
            ERASE, DRAW: begin
                plot_x_n = sum_x[7:0];
                plot_y_n = sum_y[6:0];
                colour_n = (state == ERASE) ? BG_COLOUR : ALIEN_COLOUR;
                plot_n   = on_screen && ((state == ERASE) || sprite_bit);
                if (cx == CW'(SPR_W - 1)) begin
                    cx_n = '0;
                    if (cy == RW'(SPR_H - 1)) begin
                        cy_n    = '0;
                        state_n = (state == ERASE) ? DRAW : FINISH;
                    end else begin
                        cy_n = cy + 1'b1;
                    end
                end else begin
                    cx_n = cx + 1'b1;
                end
            end
            FINISH: begin
                last_x_n    = new_x;
                last_y_n    = new_y;
                first_n     = 1'b0;
                draw_done_n = 1'b1;
                busy_n      = 1'b0;
`ifdef ALIEN_SPRITE_ANIM_EN
                frame_sel_n = ~frame_sel;
`endif
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            last_x    <= '0;
            last_y    <= '0;
            new_x     <= '0;
            new_y     <= '0;
            first     <= 1'b1;
            plot_x    <= '0;
            plot_y    <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            draw_done <= 1'b0;
`ifdef ALIEN_SPRITE_ANIM_EN
            frame_sel <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cx        <= cx_n;
            cy        <= cy_n;
            last_x    <= last_x_n;
            last_y    <= last_y_n;
            new_x     <= new_x_n;
            new_y     <= new_y_n;
            first     <= first_n;
            plot_x    <= plot_x_n;
            plot_y    <= plot_y_n;
            colour    <= colour_n;
            plot      <= plot_n;
            busy      <= busy_n;
            draw_done <= draw_done_n;
`ifdef ALIEN_SPRITE_ANIM_EN
            frame_sel <= frame_sel_n;
`endif
        end
    end

endmodule

// File: tb/tb_alien_sprite_drawer.sv
// Bench for alien_sprite_drawer: scripted and random moves checked pixel-by-pixel
// against a model that lists the erase/draw writes each move should produce.
module tb_alien_sprite_drawer;

    localparam int W = 8;
    localparam int H = 8;
    localparam logic [63:0] BITS_A = 64'h3C7EDBFFFF246681;
    localparam logic [63:0] BITS_B = 64'h3C7EDBFFFF5A8142;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alien_x;
    logic [6:0] alien_y;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] colour;
    logic       plot, busy, draw_done;

    always #5 clk = ~clk;

    alien_sprite_drawer dut (
        .clk(clk), .reset(reset), .alien_x(alien_x), .alien_y(alien_y),
        .plot_x(plot_x), .plot_y(plot_y), .colour(colour),
        .plot(plot), .busy(busy), .draw_done(draw_done)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what has been drawn so far, and the per-slot writes of the next pass.
    int          m_last_x, m_last_y;
    logic        m_first, m_frame;
    int          last_plots;
    logic [18:0] exp_q[$];

    function automatic logic [18:0] pix(input logic p, input int x, input int y, input logic [2:0] c);
        if (!p) return 19'd0;
        return {1'b1, x[7:0], y[6:0], c};
    endfunction

    task automatic build_pass(input int nx, input int ny);
        logic [63:0] bits;
        int x, y;
        bits = BITS_A;
`ifdef ALIEN_SPRITE_ANIM_EN
        if (m_frame) bits = BITS_B;
`endif
        if (!m_first)
            for (int k = 0; k < W * H; k++) begin
                x = m_last_x + k % W;
                y = m_last_y + k / W;
                exp_q.push_back(pix((x < 160) && (y < 120), x, y, 3'b000));
            end
        for (int k = 0; k < W * H; k++) begin
            x = nx + k % W;
            y = ny + k / W;
            exp_q.push_back(pix(bits[k] && (x < 160) && (y < 120), x, y, 3'b010));
        end
    endtask

    // Called at a falling edge with the DUT idle and inputs already pointing at (nx,ny).
    task automatic run_pass(input int nx, input int ny, input int m1s, input int m1x,
                            input int m2s, input int m2x, input int abort_slot);
        int slots;
        logic [18:0] got, e;
        last_plots = 0;
        build_pass(nx, ny);
        slots = exp_q.size();
        @(posedge clk); @(negedge clk);
        check("busy_on_detect", {busy, plot, draw_done}, 3'b100);
        for (int s = 1; s <= slots; s++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            got = plot ? {1'b1, plot_x, plot_y, colour} : 19'd0;
            check($sformatf("pix_%0d_%0d", nx, s), got, e);
            check("busy_mid", {busy, draw_done}, 2'b10);
            last_plots += int'(plot);
            if (s == m1s) alien_x = m1x[7:0];
            if (s == m2s) alien_x = m2x[7:0];
            if (s == abort_slot) begin
                reset = 1'b1;
                #1;
                check("abort_outputs", {plot, plot_x, plot_y, colour, busy, draw_done}, 21'd0);
                @(negedge clk);
                reset = 1'b0;
                m_first = 1'b1;
                m_frame = 1'b0;
                m_last_x = 0;
                m_last_y = 0;
                exp_q.delete();
                return;
            end
        end
        @(posedge clk); @(negedge clk);
        check("finish", {draw_done, busy, plot}, 3'b100);
        m_last_x = nx;
        m_last_y = ny;
        m_first = 1'b0;
        m_frame = ~m_frame;
    endtask

    task automatic move(input int nx, input int ny);
        alien_x = nx[7:0];
        alien_y = ny[6:0];
        run_pass(nx, ny, -1, 0, -1, 0, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nx, ny;
        reset = 1'b1;
        alien_x = 8'd66;
        alien_y = 7'd15;
        m_first = 1'b1;
        m_frame = 1'b0;
        m_last_x = 0;
        m_last_y = 0;
        repeat (3) @(negedge clk);
        check("rst_plot", plot, 1'b0);
        check("rst_plot_x", plot_x, 8'd0);
        check("rst_plot_y", plot_y, 7'd0);
        check("rst_colour", colour, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_draw_done", draw_done, 1'b0);
        reset = 1'b0;

        // First draw after reset: draw-only pass, every bitmap pixel on screen.
        run_pass(66, 15, -1, 0, -1, 0, -1);
        check("first_popcount", last_plots, $countones(BITS_A));

        // Single-step move: full erase of the old box then draw.
        move(67, 15);
        check("step_plots", last_plots, 64 + $countones(BITS_B) * (m_frame ? 1 : 0)
              + $countones(BITS_A) * (m_frame ? 0 : 1)
`ifndef ALIEN_SPRITE_ANIM_EN
              - $countones(BITS_B) * (m_frame ? 1 : 0) + $countones(BITS_A) * (m_frame ? 1 : 0)
`endif
              );

        // Steady inputs: nothing happens.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); @(negedge clk);
            check("idle_quiet", {plot, busy, draw_done}, 3'b000);
        end

        // Moves while busy are dropped except for the most recent one.
        alien_x = 8'd68;
        run_pass(68, 15, 10, 70, 80, 71, -1);
        run_pass(71, 15, -1, 0, -1, 0, -1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("after_latest", {plot, busy}, 2'b00);
        end

        // Clipping at the bottom-right corner, then move away (erase is clipped too).
        move(156, 115);
        move(150, 100);

        // Reset in the middle of the erase pass, then a draw-only pass at the same inputs.
        alien_x = 8'd40;
        alien_y = 7'd30;
        run_pass(40, 30, -1, 0, -1, 0, 20);
        run_pass(40, 30, -1, 0, -1, 0, -1);
        check("redraw_after_abort", last_plots, $countones(BITS_A));

        // Random moves, some with an input change landing mid-pass.
        for (int i = 0; i < 14; i++) begin
            nx = $urandom_range(0, 163);
            ny = $urandom_range(0, 123);
            if (nx == m_last_x && ny == m_last_y) nx = (nx + 1) % 164;
            alien_x = nx[7:0];
            alien_y = ny[6:0];
            if ($urandom_range(0, 1) == 1)
                run_pass(nx, ny, $urandom_range(1, 120), $urandom_range(0, 163), -1, 0, -1);
            else
                run_pass(nx, ny, -1, 0, -1, 0, -1);
            if (int'(alien_x) != m_last_x)
                run_pass(int'(alien_x), int'(alien_y), -1, 0, -1, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
